stupidrv_icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the stupidrv core's instruction port and a valid/ready memory bus. It returns the word for the address the core presented on the previous un-stalled cycle. On a miss it holds the core via `stall`, fetches the word over the bus, fills the line and releases the core.

---
 rtl/stupidrv_pkg.sv | 22 ++
 rtl/stupidrv_icache_array.sv | 58 +++++
 rtl/stupidrv_icache.sv | 132 +++++++++++++
 tb/tb_stupidrv_icache.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stupidrv_pkg.sv
// Shared definitions for the stupidrv core and its instruction cache:
// reset address, cache FSM states and geometry helpers.
package stupidrv_pkg;

    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } icache_state_e;

    function automatic int unsigned icache_index_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Word addressing drops two bits; the index takes the next log2(entries).
    function automatic int unsigned icache_tag_width(input int unsigned entries);
        return 32'd30 - $clog2(entries);
    endfunction

endpackage

// File: rtl/stupidrv_icache_array.sv
// Line storage for the instruction cache: valid bits, tags and data words with
// one combinational read port, one write port and a synchronous clear.
module stupidrv_icache_array
    import stupidrv_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = icache_index_width(ENTRIES),
    parameter int unsigned TAG_W   = icache_tag_width(ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             write_en,
    input  logic [IDX_W-1:0] write_index,
    input  logic [TAG_W-1:0] write_tag,
    input  logic [31:0]      write_data,
    input  logic [IDX_W-1:0] read_index,
    output logic             read_valid,
    output logic [TAG_W-1:0] read_tag,
    output logic [31:0]      read_data
);

    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r  [ENTRIES];
    logic [31:0]        data_r [ENTRIES];

    // Valid bits: cleared by reset or flush; a clear beats a same-cycle fill.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (write_en) begin
            valid_r[write_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage; data is zeroed on reset so the read port never shows X.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                data_r[i] <= 32'h0000_0000;
            end
        end else if (write_en && !clear) begin
            tag_r[write_index]  <= write_tag;
            data_r[write_index] <= write_data;
        end else begin
            tag_r  <= tag_r;
            data_r <= data_r;
        end
    end

    assign read_valid = valid_r[read_index];
    assign read_tag   = tag_r[read_index];
    assign read_data  = data_r[read_index];

endmodule

// File: rtl/stupidrv_icache.sv
// Direct-mapped, one-word-per-line instruction cache between the stupidrv
// fetch port and a valid/ready read bus; misses stall the core until filled.
module stupidrv_icache
    import stupidrv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int unsigned ENTRIES    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        stall,
    input  logic        flush,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned IDX_W = icache_index_width(ENTRIES);
    localparam int unsigned TAG_W = icache_tag_width(ENTRIES);

    icache_state_e    state_r;
    icache_state_e    state_s;
    logic [31:0]      addr_r;
    logic             mem_valid_r;
    logic [31:0]      mem_addr_r;
    logic             drop_r;
    logic             fill_s;
    logic             hit_s;
    logic [IDX_W-1:0] index_s;
    logic [TAG_W-1:0] tag_s;
    logic             line_valid_s;
    logic [TAG_W-1:0] line_tag_s;
    logic             unused_addr_bits_s;

    assign index_s            = addr_r[2 +: IDX_W];
    assign tag_s              = addr_r[31 -: TAG_W];
    assign unused_addr_bits_s = ^addr_r[1:0];

    stupidrv_icache_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clock       (clock),
        .reset       (reset),
        .clear       (flush),
        .write_en    (fill_s),
        .write_index (index_s),
        .write_tag   (tag_s),
        .write_data  (mem_rdata),
        .read_index  (index_s),
        .read_valid  (line_valid_s),
        .read_tag    (line_tag_s),
        .read_data   (imem_data)
    );

    assign hit_s     = (state_r == IDLE) && line_valid_s && (line_tag_s == tag_s);
    assign stall     = ~reset & ~hit_s;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;

    // Next-state logic; a fill is suppressed if a flush landed during the fetch.
    always_comb begin
        state_s = state_r;
        fill_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_s = IDLE;
                    fill_s  = ~flush & ~drop_r;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
                fill_s  = 1'b0;
            end
        endcase
    end

    // FSM, captured fetch address and registered bus request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= RESET_ADDR;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= RESET_ADDR;
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_valid_r <= (state_s == REQ);
            if (!stall) begin
                addr_r <= imem_addr;
            end else begin
                addr_r <= addr_r;
            end
            // The request address is latched once on entry to REQ and held until accepted.
            if ((state_r == IDLE) && (state_s == REQ)) begin
                mem_addr_r <= {addr_r[31:2], 2'b00};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (state_s == IDLE) begin
                drop_r <= 1'b0;
            end else if (flush && (state_r != IDLE)) begin
                drop_r <= 1'b1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

endmodule

// File: tb/tb_stupidrv_icache.sv
// Directed, table-driven bench for stupidrv_icache (ENTRIES=8, RESET_ADDR=0)
// with a hand-written back-pressure sequence.
module tb_stupidrv_icache;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic        flush;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        es;
        logic        emv;
        logic        cha;
        logic [31:0] emaddr;
        logic        chd;
        logic [31:0] edata;
    } vec_t;

    localparam logic [31:0] D0  = 32'h0000_0013;
    localparam logic [31:0] D4  = 32'h0040_0093;
    localparam logic [31:0] D8  = 32'h0080_0113;
    localparam logic [31:0] D20 = 32'h00a0_0193;
    localparam logic [31:0] D40 = 32'h1234_5678;
    localparam logic [31:0] D44 = 32'h0bad_f00d;
    localparam logic [31:0] DX  = 32'hdead_beef;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    stupidrv_icache #(
        .RESET_ADDR (32'h0000_0000),
        .ENTRIES    (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [31:0] addr, input logic fl,
                       input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic es, input logic emv, input logic cha,
                       input logic [31:0] emaddr, input logic chd, input logic [31:0] edata);
        vec_t v;
        v.rst = rst; v.addr = addr; v.flush = fl; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.es = es; v.emv = emv; v.cha = cha; v.emaddr = emaddr; v.chd = chd; v.edata = edata;
        vecs.push_back(v);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clock);
            reset      = vecs[i].rst;
            imem_addr  = vecs[i].addr;
            flush      = vecs[i].flush;
            mem_ready  = vecs[i].rdy;
            mem_rvalid = vecs[i].rv;
            mem_rdata  = vecs[i].rdata;
            #1;
            check32($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].es});
            check32($sformatf("row%0d mem_valid", i), {31'd0, mem_valid}, {31'd0, vecs[i].emv});
            if (vecs[i].cha) check32($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].emaddr);
            if (vecs[i].chd) check32($sformatf("row%0d imem_data", i), imem_data, vecs[i].edata);
        end
    endtask

    initial begin
        int part1;
        int stall_cnt;
        logic done;

        reset = 1'b1; imem_addr = 32'h0; flush = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //  rst addr   fl rdy rv rdata   es mv cha maddr   chd data
        // Reset, cold start on 0x0, fill 0x4 and 0x8.
        add(1, 32'h00, 0, 0, 0, 32'h0, 0, 0, 1, 32'h00, 1, 32'h0);
        add(1, 32'h00, 0, 0, 0, 32'h0, 0, 0, 1, 32'h00, 1, 32'h0);
        add(0, 32'h00, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 1, 0, 32'h0, 1, 1, 1, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 0, 1, D0,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h04, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D0);
        add(0, 32'h04, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h04, 0, 1, 0, 32'h0, 1, 1, 1, 32'h04, 0, 32'h0);
        add(0, 32'h04, 0, 0, 1, D4,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h08, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D4);
        add(0, 32'h08, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h08, 0, 1, 0, 32'h0, 1, 1, 1, 32'h08, 0, 32'h0);
        add(0, 32'h08, 0, 0, 1, D8,    1, 0, 0, 32'h00, 0, 32'h0);
        // Hit streaming replay; a stray rvalid in IDLE must be ignored.
        add(0, 32'h00, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D8);
        add(0, 32'h04, 0, 0, 1, DX,    0, 0, 0, 32'h00, 1, D0);
        add(0, 32'h08, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D4);
        add(0, 32'h20, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D8);
        // Conflict on index 0: 0x20 evicts 0x00, then 0x00 misses again.
        add(0, 32'h20, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h20, 0, 1, 0, 32'h0, 1, 1, 1, 32'h20, 0, 32'h0);
        add(0, 32'h20, 0, 0, 1, D20,   1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D20);
        add(0, 32'h00, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 1, 0, 32'h0, 1, 1, 1, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 0, 1, D0,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h40, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D0);
        part1 = vecs.size();
        // Flush during a hit, then flush in WAIT before the response.
        add(0, 32'h40, 1, 0, 0, D40,   0, 0, 0, 32'h00, 1, D40);
        add(0, 32'h40, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h40, 0, 1, 0, 32'h0, 1, 1, 1, 32'h40, 0, 32'h0);
        add(0, 32'h40, 1, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h40, 0, 0, 1, DX,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h40, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h40, 0, 1, 0, 32'h0, 1, 1, 1, 32'h40, 0, 32'h0);
        add(0, 32'h40, 0, 0, 1, D40,   1, 0, 0, 32'h00, 0, 32'h0);
        // Fill and flush in the same cycle: flush wins.
        add(0, 32'h44, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D40);
        add(0, 32'h44, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 1, 0, 32'h0, 1, 1, 1, 32'h44, 0, 32'h0);
        add(0, 32'h44, 1, 0, 1, DX,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 1, 0, 32'h0, 1, 1, 1, 32'h44, 0, 32'h0);
        add(0, 32'h44, 0, 0, 1, D44,   1, 0, 0, 32'h00, 0, 32'h0);
        // Reset while in REQ on 0x80.
        add(0, 32'h80, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D44);
        add(0, 32'h80, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(1, 32'h80, 0, 0, 0, 32'h0, 0, 1, 1, 32'h80, 0, 32'h0);
        add(1, 32'h00, 0, 0, 0, 32'h0, 0, 0, 1, 32'h00, 1, 32'h0);
        add(0, 32'h00, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 1, 32'h0);
        add(0, 32'h00, 0, 1, 0, 32'h0, 1, 1, 1, 32'h00, 0, 32'h0);
        add(0, 32'h00, 0, 0, 1, D0,    1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D0);
        add(0, 32'h44, 0, 0, 0, 32'h0, 1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 1, 0, 32'h0, 1, 1, 1, 32'h44, 0, 32'h0);
        add(0, 32'h44, 0, 0, 1, D44,   1, 0, 0, 32'h00, 0, 32'h0);
        add(0, 32'h44, 0, 0, 0, 32'h0, 0, 0, 0, 32'h00, 1, D44);

        run_rows(0, part1);

        // Back-pressure on 0x40: ready held low for 5 REQ cycles.
        stall_cnt = 0;
        done      = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            reset = 1'b0; flush = 1'b0; imem_addr = 32'h40;
            mem_ready = (c == 6); mem_rvalid = (c == 7); mem_rdata = D40;
            #1;
            if (c == 0) check32("bp idle mem_valid", {31'd0, mem_valid}, 32'd0);
            if (c >= 1 && c <= 6) begin
                check32($sformatf("bp c%0d mem_valid", c), {31'd0, mem_valid}, 32'd1);
                check32($sformatf("bp c%0d mem_addr", c), mem_addr, 32'h40);
            end
            if (stall) begin
                stall_cnt++;
            end else begin
                check32("bp hit data", imem_data, D40);
                done = 1'b1;
            end
        end
        check32("bp completed", {31'd0, done}, 32'd1);
        check32("bp stall cycles", stall_cnt, 32'd8);

        run_rows(part1, vecs.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
